// File: rtl/rod_pkg.sv
// rod_pkg: shared rod state encoding, default geometry and derived-constant helpers
// Contents:
//   rod_state_t    2-bit FSM state, also exported on the top-level state port
//   *_DEF          default geometry used as parameter defaults by rod_motion_ctrl
//   lowered_y()    top edge of the sprite box when fully lowered
package rod_pkg;
   typedef enum logic [1:0] {
      RAISED   = 2'd0,
      LOWERING = 2'd1,
      LOWERED  = 2'd2,
      RAISING  = 2'd3
   } rod_state_t;
   localparam int ROD_X0_DEF   = 564;
   localparam int ROD_Y_UP_DEF = 210;
   localparam int TRAVEL_DEF   = 48;
   localparam int STEP_DEF     = 2;
   localparam int SPRITE_W_DEF = 64;
   localparam int SPRITE_H_DEF = 16;
   localparam int ADDR_W_DEF   = 10;
   localparam int SPRITE_SHIFT_DEF = $clog2(SPRITE_W_DEF);
   function automatic int lowered_y(input int y_up, input int travel);
      return y_up + travel;
   endfunction
endpackage

// File: rtl/rod_motion_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse on each falling edge of active-low vsync
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset (delayed vsync resets high)
//   i_vsync  active-low vsync, synchronous to i_clk
//   o_tick   high for the single cycle in which vsync first goes low
module frame_tick_gen (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vsync,
   output logic o_tick
);
   logic r_vsync_d;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_vsync_d <= 1'b1;
      else          r_vsync_d <= i_vsync;
   end
   assign o_tick = r_vsync_d & ~i_vsync;
endmodule

// File: rtl/rod_motion_ctrl.sv
// rod_motion_ctrl: frame-stepped rod (gate) sprite sequencer and sprite address generator
// Ports:
//   vga_clk      pixel clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   vsync        active-low vsync; position only changes on its falling edge
//   trigger      level, 1 = rod should be lowered; sampled only on frame ticks
//   DrawX/DrawY  current pixel
//   rod_y        current top edge of the rod box
//   rom_address  sprite ROM address, combinational, 0 outside the box
//   rod_on       pixel-in-box flag delayed one cycle to line up with ROM data
//   state        rod_state_t
//   at_bottom    state == LOWERED
//   moving       state == LOWERING or RAISING
module rod_motion_ctrl
   import rod_pkg::*;
#(
   parameter int ROD_X0   = ROD_X0_DEF,
   parameter int ROD_Y_UP = ROD_Y_UP_DEF,
   parameter int TRAVEL   = TRAVEL_DEF,
   parameter int STEP     = STEP_DEF,
   parameter int SPRITE_W = SPRITE_W_DEF,
   parameter int SPRITE_H = SPRITE_H_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic              vsync,
   input  logic              trigger,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [9:0]        rod_y,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rod_on,
   output rod_state_t        state,
   output logic              at_bottom,
   output logic              moving
);
   localparam int SHIFT = $clog2(SPRITE_W);
   // 11-bit constants so the clamp compares cannot wrap at 10 bits
   localparam logic [10:0] Y_UP      = 11'(ROD_Y_UP);
   localparam logic [10:0] Y_DN      = 11'(lowered_y(ROD_Y_UP, TRAVEL));
   localparam logic [10:0] Y_UP_STEP = 11'(ROD_Y_UP + STEP);
   localparam logic [10:0] X_LO      = 11'(ROD_X0);
   localparam logic [10:0] X_HI      = 11'(ROD_X0 + SPRITE_W);
   rod_state_t  r_state, w_state_nxt;
   logic [9:0]  r_rod_y, w_rod_y_nxt;
   logic        r_rod_on;
   logic        w_tick;
   logic        w_in_box;
   logic [10:0] w_ry, w_y_dn, w_x, w_dy, w_off_x, w_off_y;
   frame_tick_gen u_tick (
      .i_clk   (vga_clk),
      .i_rst_n (reset_n),
      .i_vsync (vsync),
      .o_tick  (w_tick)
   );
   assign w_ry   = {1'b0, r_rod_y};
   assign w_y_dn = w_ry + 11'(STEP);
   // A reversal only changes direction on its tick; the step resumes on the next tick
   always_comb begin
      w_state_nxt = r_state;
      w_rod_y_nxt = r_rod_y;
      if (w_tick) begin
         case (r_state)
            RAISED:   w_state_nxt = trigger ? LOWERING : RAISED;
            LOWERED:  w_state_nxt = trigger ? LOWERED : RAISING;
            LOWERING: begin
               if (!trigger) w_state_nxt = RAISING;
               else if (w_y_dn >= Y_DN) begin
                  w_state_nxt = LOWERED;
                  w_rod_y_nxt = Y_DN[9:0];
               end else w_rod_y_nxt = w_y_dn[9:0];
            end
            RAISING: begin
               if (trigger) w_state_nxt = LOWERING;
               else if (w_ry <= Y_UP_STEP) begin
                  w_state_nxt = RAISED;
                  w_rod_y_nxt = Y_UP[9:0];
               end else w_rod_y_nxt = r_rod_y - 10'(STEP);
            end
         endcase
      end
   end
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= RAISED;
         r_rod_y  <= Y_UP[9:0];
         r_rod_on <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rod_y  <= w_rod_y_nxt;
         r_rod_on <= w_in_box;
      end
   end
   assign w_x      = {1'b0, DrawX};
   assign w_dy     = {1'b0, DrawY};
   assign w_in_box = (w_x >= X_LO) && (w_x < X_HI) && (w_dy >= w_ry) && (w_dy < w_ry + 11'(SPRITE_H));
   assign w_off_x  = w_x - X_LO;
   assign w_off_y  = w_dy - w_ry;
   assign rom_address = w_in_box ? ADDR_W'(w_off_x) + (ADDR_W'(w_off_y) << SHIFT) : '0;
   assign rod_y     = r_rod_y;
   assign rod_on    = r_rod_on;
   assign state     = r_state;
   assign at_bottom = (r_state == LOWERED);
   assign moving    = (r_state == LOWERING) || (r_state == RAISING);
endmodule
